// File: rtl/stream_arbiter_mux.sv
// N-to-1 registered stream multiplexer with fixed-priority or round-robin arbitration.
// The grant can be held from the first beat of a packet until its last beat.
module stream_arbiter_mux #(
  parameter int DATA_WIDTH   = 8,
  parameter int NUM_INPUTS   = 4,
  parameter int ARB_MODE     = 0,
  parameter int LOCK_ON_LAST = 1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_INPUTS-1:0]            in_valid,
  output logic [NUM_INPUTS-1:0]            in_ready,
  input  logic [NUM_INPUTS*DATA_WIDTH-1:0] in_data,
  input  logic [NUM_INPUTS-1:0]            in_last,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [DATA_WIDTH-1:0]            out_data,
  output logic                             out_last,
  output logic [NUM_INPUTS-1:0]            out_sel
);

  localparam int IDX_W = $clog2(NUM_INPUTS);

  typedef enum logic {
    IDLE,
    LOCKED
  } state_e;

  state_e                  state, state_next;
  logic [IDX_W-1:0]        lock_ch, lock_ch_next;
  logic [IDX_W-1:0]        rr_ptr, rr_ptr_next;

  logic [NUM_INPUTS-1:0]   grant;
  logic [IDX_W-1:0]        grant_idx;
  logic [IDX_W-1:0]        cand;
  logic                    found;
  logic                    can_load;
  logic                    take;
  logic                    take_last;

  assign can_load = !out_valid || out_ready;

  // NOTE: every signal written here gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    cand      = '0;
    found     = 1'b0;
    if (state == LOCKED) begin
      if (in_valid[lock_ch]) begin
        grant[lock_ch] = 1'b1;
        grant_idx      = lock_ch;
      end
    end else if (ARB_MODE == 0) begin
      for (int i = 0; i < NUM_INPUTS; i++) begin
        if (!found && in_valid[i]) begin
          found     = 1'b1;
          grant[i]  = 1'b1;
          grant_idx = IDX_W'(i);
        end
      end
    end else begin
      for (int k = 0; k < NUM_INPUTS; k++) begin
        cand = IDX_W'((int'(rr_ptr) + k) % NUM_INPUTS);
        if (!found && in_valid[cand]) begin
          found       = 1'b1;
          grant[cand] = 1'b1;
          grant_idx   = cand;
        end
      end
    end
  end

  // Reset forces all ready low so nothing is accepted into a register being cleared.
  assign in_ready  = rst ? '0 : (grant & {NUM_INPUTS{can_load}});
  assign take      = |in_ready;
  assign take_last = in_last[grant_idx];

  always_comb begin
    state_next   = state;
    lock_ch_next = lock_ch;
    rr_ptr_next  = rr_ptr;
    if (take) begin
      if (LOCK_ON_LAST != 0) begin
        if (take_last) begin
          state_next = IDLE;
        end else begin
          state_next   = LOCKED;
          lock_ch_next = grant_idx;
        end
      end
      if ((LOCK_ON_LAST == 0) || take_last) begin
        rr_ptr_next = (grant_idx == IDX_W'(NUM_INPUTS - 1)) ? '0 : grant_idx + IDX_W'(1);
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      lock_ch <= '0;
      rr_ptr  <= '0;
    end else begin
      state   <= state_next;
      lock_ch <= lock_ch_next;
      rr_ptr  <= rr_ptr_next;
    end
  end

  // NOTE: the payload register is reset too, because a known zero output after
  // reset is part of this block's contract rather than a don't-care.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      out_sel   <= '0;
    end else if (take) begin
      out_valid <= 1'b1;
      out_data  <= in_data[grant_idx*DATA_WIDTH +: DATA_WIDTH];
      out_last  <= take_last;
      out_sel   <= grant;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_stream_arbiter_mux.sv
// Bench for stream_arbiter_mux: four instances covering every ARB_MODE/LOCK_ON_LAST pair,
// directed vectors for the corner cases, then random traffic against a reference model.
module tb_stream_arbiter_mux;

  localparam int N  = 4;
  localparam int DW = 8;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    in_valid;
  logic [N-1:0]    in_last;
  logic [N*DW-1:0] in_data;
  logic            out_ready;

  logic [N-1:0]    rdy [4];
  logic            ov  [4];
  logic [DW-1:0]   od  [4];
  logic            ol  [4];
  logic [N-1:0]    os  [4];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Instance c: ARB_MODE = c/2, LOCK_ON_LAST = c%2.
  for (genvar g = 0; g < 4; g++) begin : g_dut
    stream_arbiter_mux #(
      .DATA_WIDTH(DW), .NUM_INPUTS(N), .ARB_MODE(g / 2), .LOCK_ON_LAST(g % 2)
    ) u_dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(rdy[g]), .in_data(in_data), .in_last(in_last),
      .out_valid(ov[g]), .out_ready(out_ready), .out_data(od[g]), .out_last(ol[g]),
      .out_sel(os[g])
    );
  end

  typedef struct {
    logic [N-1:0]  valid;
    logic          ordy;
    logic [N-1:0]  exp_ready;
    logic          exp_ov;
    logic [DW-1:0] exp_od;
    logic [N-1:0]  exp_os;
  } vec_t;

  vec_t fp_tab [7];

  // Reference model state per instance; sel = -1 means no source yet.
  int m_ov [4], m_od [4], m_ol [4], m_os [4], m_lk [4], m_lch [4], m_rr [4];
  int m_g  [4], m_take [4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [N-1:0] v, input logic [N-1:0] l, input logic r);
    in_valid  = v;
    in_last   = l;
    out_ready = r;
    #1;
  endtask

  task automatic set_data(input logic [DW-1:0] d0, input logic [DW-1:0] d1,
                          input logic [DW-1:0] d2, input logic [DW-1:0] d3);
    in_data = {d3, d2, d1, d0};
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive('0, '0, 1'b1);
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic chk_out(input int c, input string name, input logic v,
                         input logic [DW-1:0] d, input logic [N-1:0] s);
    check($sformatf("%s c%0d out_valid", name, c), 32'(ov[c]), 32'(v));
    check($sformatf("%s c%0d out_data", name, c), 32'(od[c]), 32'(d));
    check($sformatf("%s c%0d out_sel", name, c), 32'(os[c]), 32'(s));
  endtask

  function automatic int model_pick(input int c);
    int i;
    if (m_lk[c] != 0) return in_valid[m_lch[c]] ? m_lch[c] : -1;
    for (int k = 0; k < N; k++) begin
      i = (c / 2 == 0) ? k : (m_rr[c] + k) % N;
      if (in_valid[i]) return i;
    end
    return -1;
  endfunction

  task automatic model_reset();
    for (int c = 0; c < 4; c++) begin
      m_ov[c] = 0; m_od[c] = 0; m_ol[c] = 0; m_os[c] = -1;
      m_lk[c] = 0; m_lch[c] = 0; m_rr[c] = 0;
    end
  endtask

  initial begin
    fp_tab[0] = '{4'b1111, 1'b1, 4'b0001, 1'b1, 8'h10, 4'b0001};
    fp_tab[1] = '{4'b1111, 1'b1, 4'b0001, 1'b1, 8'h10, 4'b0001};
    fp_tab[2] = '{4'b1110, 1'b1, 4'b0010, 1'b1, 8'h11, 4'b0010};
    fp_tab[3] = '{4'b1110, 1'b0, 4'b0000, 1'b1, 8'h11, 4'b0010};
    fp_tab[4] = '{4'b0000, 1'b1, 4'b0000, 1'b0, 8'h11, 4'b0010};
    fp_tab[5] = '{4'b1000, 1'b1, 4'b1000, 1'b1, 8'h13, 4'b1000};
    fp_tab[6] = '{4'b0000, 1'b0, 4'b0000, 1'b1, 8'h13, 4'b1000};

    rst = 1'b1;
    set_data(8'h10, 8'h11, 8'h12, 8'h13);
    drive(4'b1111, 4'b1111, 1'b1);

    // Reset: no ready while rst is high, all outputs cleared afterwards.
    tick();
    for (int c = 0; c < 4; c++) check($sformatf("rst c%0d in_ready", c), 32'(rdy[c]), 32'h0);
    tick();
    for (int c = 0; c < 4; c++) begin
      chk_out(c, "rst", 1'b0, 8'h00, 4'b0000);
      check($sformatf("rst c%0d out_last", c), 32'(ol[c]), 32'h0);
    end
    rst = 1'b0;

    // Fixed priority, no lock.
    do_reset();
    for (int i = 0; i < 7; i++) begin
      drive(fp_tab[i].valid, 4'b1111, fp_tab[i].ordy);
      check($sformatf("fp[%0d] in_ready", i), 32'(rdy[0]), 32'(fp_tab[i].exp_ready));
      tick();
      chk_out(0, $sformatf("fp[%0d]", i), fp_tab[i].exp_ov, fp_tab[i].exp_od, fp_tab[i].exp_os);
    end

    // Round-robin, no lock: full rate rotation.
    do_reset();
    drive(4'b1111, 4'b1111, 1'b1);
    for (int k = 0; k < 5; k++) begin
      check($sformatf("rr[%0d] in_ready", k), 32'(rdy[2]), 32'(1 << (k % N)));
      tick();
      chk_out(2, $sformatf("rr[%0d]", k), 1'b1, 8'(8'h10 + k % N), 4'(1 << (k % N)));
    end

    // Round-robin with packet lock on ch2.
    do_reset();
    set_data(8'h20, 8'h21, 8'hA0, 8'h23);
    drive(4'b0010, 4'b1111, 1'b1);
    check("lk a in_ready", 32'(rdy[3]), 32'b0010);
    tick();
    chk_out(3, "lk a", 1'b1, 8'h21, 4'b0010);
    drive(4'b0111, 4'b1011, 1'b1);
    check("lk b in_ready", 32'(rdy[3]), 32'b0100);
    tick();
    chk_out(3, "lk b", 1'b1, 8'hA0, 4'b0100);
    check("lk b out_last", 32'(ol[3]), 32'h0);
    set_data(8'h20, 8'h21, 8'hA1, 8'h23);
    drive(4'b0111, 4'b1011, 1'b1);
    check("lk c in_ready", 32'(rdy[3]), 32'b0100);
    tick();
    chk_out(3, "lk c", 1'b1, 8'hA1, 4'b0100);
    drive(4'b0011, 4'b1011, 1'b1);
    check("lk gap in_ready", 32'(rdy[3]), 32'b0000);
    tick();
    check("lk gap out_valid", 32'(ov[3]), 32'h0);
    set_data(8'h20, 8'h21, 8'hA2, 8'h23);
    drive(4'b0111, 4'b1111, 1'b1);
    check("lk e in_ready", 32'(rdy[3]), 32'b0100);
    tick();
    chk_out(3, "lk e", 1'b1, 8'hA2, 4'b0100);
    check("lk e out_last", 32'(ol[3]), 32'h1);
    drive(4'b0011, 4'b1111, 1'b1);
    check("lk f in_ready", 32'(rdy[3]), 32'b0001);
    tick();
    chk_out(3, "lk f", 1'b1, 8'h20, 4'b0001);

    // Backpressure, then drain and load in one cycle.
    do_reset();
    set_data(8'h20, 8'h21, 8'h22, 8'h23);
    drive(4'b0011, 4'b1111, 1'b1);
    tick();
    for (int k = 0; k < 5; k++) begin
      drive(4'b0011, 4'b1111, 1'b0);
      check($sformatf("bp[%0d] c0 in_ready", k), 32'(rdy[0]), 32'h0);
      check($sformatf("bp[%0d] c3 in_ready", k), 32'(rdy[3]), 32'h0);
      tick();
      chk_out(0, $sformatf("bp[%0d]", k), 1'b1, 8'h20, 4'b0001);
      chk_out(3, $sformatf("bp[%0d]", k), 1'b1, 8'h20, 4'b0001);
    end
    drive(4'b0011, 4'b1111, 1'b1);
    check("bp rel c0 in_ready", 32'(rdy[0]), 32'b0001);
    check("bp rel c3 in_ready", 32'(rdy[3]), 32'b0010);
    tick();
    chk_out(0, "bp rel", 1'b1, 8'h20, 4'b0001);
    chk_out(3, "bp rel", 1'b1, 8'h21, 4'b0010);

    // Reset in the middle of a locked ch1 packet.
    do_reset();
    drive(4'b0010, 4'b0000, 1'b1);
    check("rmid load in_ready", 32'(rdy[3]), 32'b0010);
    tick();
    chk_out(3, "rmid load", 1'b1, 8'h21, 4'b0010);
    rst = 1'b1;
    drive(4'b0011, 4'b0000, 1'b1);
    check("rmid rst in_ready", 32'(rdy[3]), 32'h0);
    tick();
    chk_out(3, "rmid rst", 1'b0, 8'h00, 4'b0000);
    rst = 1'b0;
    drive(4'b0011, 4'b1111, 1'b1);
    check("rmid after in_ready", 32'(rdy[3]), 32'b0001);
    tick();
    chk_out(3, "rmid after", 1'b1, 8'h20, 4'b0001);

    // Random traffic against the reference model.
    do_reset();
    model_reset();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      rst       = ($urandom_range(0, 63) == 0);
      in_data   = N*DW'($urandom);
      drive(N'($urandom), N'($urandom), ($urandom_range(0, 3) != 0));
      for (int c = 0; c < 4; c++) begin
        m_g[c]    = model_pick(c);
        m_take[c] = (!rst && m_g[c] >= 0 && (m_ov[c] == 0 || out_ready)) ? 1 : 0;
        check($sformatf("rnd%0d c%0d in_ready", cyc, c), 32'(rdy[c]),
              (m_take[c] != 0) ? 32'(1 << m_g[c]) : 32'h0);
      end
      tick();
      for (int c = 0; c < 4; c++) begin
        if (rst) begin
          m_ov[c] = 0; m_od[c] = 0; m_ol[c] = 0; m_os[c] = -1;
          m_lk[c] = 0; m_lch[c] = 0; m_rr[c] = 0;
        end else if (m_take[c] != 0) begin
          m_ov[c] = 1;
          m_od[c] = int'(in_data[m_g[c]*DW +: DW]);
          m_ol[c] = int'(in_last[m_g[c]]);
          m_os[c] = m_g[c];
          if (c % 2 == 1) begin
            m_lk[c] = (m_ol[c] == 0) ? 1 : 0;
            if (m_ol[c] == 0) m_lch[c] = m_g[c];
          end
          if (c % 2 == 0 || m_ol[c] != 0) m_rr[c] = (m_g[c] + 1) % N;
        end else if (out_ready) begin
          m_ov[c] = 0;
        end
        check($sformatf("rnd%0d c%0d out_valid", cyc, c), 32'(ov[c]), 32'(m_ov[c]));
        check($sformatf("rnd%0d c%0d out_data", cyc, c), 32'(od[c]), 32'(m_od[c]));
        check($sformatf("rnd%0d c%0d out_last", cyc, c), 32'(ol[c]), 32'(m_ol[c]));
        check($sformatf("rnd%0d c%0d out_sel", cyc, c), 32'(os[c]),
              (m_os[c] >= 0) ? 32'(1 << m_os[c]) : 32'h0);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
